// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary word sequencer: trit encodings, op codes
// and the sequencer FSM state type.
package ternary_pkg;

  localparam logic [1:0] T0   = 2'b00;
  localparam logic [1:0] T1   = 2'b01;
  localparam logic [1:0] T2   = 2'b10;
  localparam logic [1:0] TBAD = 2'b11;

  typedef enum logic [1:0] {
    OP_MIN  = 2'b00,
    OP_MAX  = 2'b01,
    OP_ANY  = 2'b10,
    OP_CONS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic trit_bad(input logic [1:0] t);
    return t == TBAD;
  endfunction

endpackage

// File: rtl/ternary_word_sequencer_if.sv
// Host-facing request/result bus of the ternary word sequencer.
// A request transfers on a rising edge with in_valid && in_ready; a result
// transfers on a rising edge with out_valid && out_ready. Valid, once raised,
// holds with stable payload until the transfer edge.
interface ternary_word_sequencer_if #(
  parameter int NTRITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [2*NTRITS-1:0]   a;
  logic [2*NTRITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*NTRITS-1:0]   result;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

// File: rtl/ternary_op_unit.sv
// Single-trit ternary operation unit: the four gate modules plus an op mux.
// Any illegal input trit forces a 00 output and raises bad.
module ternary_min (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  assign y = (a < b) ? a : b;
endmodule

module ternary_max (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  assign y = (a > b) ? a : b;
endmodule

module ternary_any (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  import ternary_pkg::*;
  logic [1:0] lo;
  logic [1:0] hi;
  assign lo = (a < b) ? a : b;
  assign hi = (a < b) ? b : a;
  // Commutative, so only the ordered pair matters.
  always_comb begin
    y = T0;
    case ({lo, hi})
      {T0, T0}: y = T0;
      {T0, T1}: y = T0;
      {T0, T2}: y = T1;
      {T1, T1}: y = T1;
      {T1, T2}: y = T2;
      {T2, T2}: y = T2;
      default:  y = T0;
    endcase
  end
endmodule

module ternary_consensus (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  import ternary_pkg::*;
  assign y = (a == b) ? a : T1;
endmodule

module ternary_op_unit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [1:0] y,
  output logic       bad
);
  import ternary_pkg::*;

  logic [1:0] y_min;
  logic [1:0] y_max;
  logic [1:0] y_any;
  logic [1:0] y_cons;

  ternary_min       u_min  (.a(a), .b(b), .y(y_min));
  ternary_max       u_max  (.a(a), .b(b), .y(y_max));
  ternary_any       u_any  (.a(a), .b(b), .y(y_any));
  ternary_consensus u_cons (.a(a), .b(b), .y(y_cons));

  always_comb begin
    bad = trit_bad(a) || trit_bad(b);
    case (op_e'(op))
      OP_MIN:  y = y_min;
      OP_MAX:  y = y_max;
      OP_ANY:  y = y_any;
      OP_CONS: y = y_cons;
      default: y = T0;
    endcase
    if (bad) y = T0;
  end
endmodule

// File: rtl/ternary_word_sequencer.sv
// Word-level ternary sequencer: latches one request, walks its trit pairs
// through a shared op unit one per cycle, then presents the result word.
module ternary_word_sequencer #(
  parameter int NTRITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ternary_word_sequencer_if.slave  bus,
  output ternary_pkg::state_e      dbg_state
);
  import ternary_pkg::*;

  localparam int IDXW = $clog2(NTRITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTRITS - 1);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [2*NTRITS-1:0] a_q, a_d;
  logic [2*NTRITS-1:0] b_q, b_d;
  logic [2*NTRITS-1:0] result_q, result_d;
  logic                err_q, err_d;
  logic [IDXW-1:0]     idx_q, idx_d;

  logic                accept;
  logic [1:0]          unit_y;
  logic                unit_bad;
  logic [1:0]          trit_a;
  logic [1:0]          trit_b;

  assign accept = bus.in_valid && (state_q == ST_IDLE);
  assign trit_a = a_q[{idx_q, 1'b0} +: 2];
  assign trit_b = b_q[{idx_q, 1'b0} +: 2];

  ternary_op_unit u_op (
    .a   (trit_a),
    .b   (trit_b),
    .op  (op_q),
    .y   (unit_y),
    .bad (unit_bad)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
    bus.result    = result_q;
    bus.err       = err_q;
    dbg_state     = state_q;
  end

  // Datapath: operand latch, result accumulation, index counter
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = bus.op;
          a_d      = bus.a;
          b_d      = bus.b;
          result_d = '0;
          err_d    = 1'b0;
          idx_d    = '0;
        end
      end
      ST_RUN: begin
        result_d[{idx_q, 1'b0} +: 2] = unit_y;
        if (unit_bad) err_d = 1'b1;
        // Hold at the last index rather than wrapping.
        if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_ternary_word_sequencer.sv
// Self-checking bench for ternary_word_sequencer with NTRITS=4: directed
// vectors, randomized transactions, backpressure, held requests and reset.
module tb_ternary_word_sequencer;
  import ternary_pkg::*;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  ternary_word_sequencer_if #(.NTRITS(N)) bus ();

  ternary_word_sequencer #(.NTRITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {err, result} for a whole word
  function automatic logic [W:0] ref_word(input logic [1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    int any_tab[3][3] = '{'{0, 0, 1}, '{0, 1, 2}, '{1, 2, 2}};
    logic [W-1:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < N; i++) begin
      int p;
      int q;
      int v;
      p = int'(x[2*i +: 2]);
      q = int'(y[2*i +: 2]);
      if (p == 3 || q == 3) begin
        v = 0;
        e = 1'b1;
      end else begin
        case (o)
          2'd0:    v = (p < q) ? p : q;
          2'd1:    v = (p > q) ? p : q;
          2'd2:    v = any_tab[p][q];
          default: v = (p == q) ? p : 1;
        endcase
      end
      r[2*i +: 2] = v[1:0];
    end
    return {e, r};
  endfunction

  function automatic logic [W-1:0] rand_word(input int bad_pct);
    logic [W-1:0] w;
    for (int i = 0; i < N; i++)
      w[2*i +: 2] = ($urandom_range(0, 99) < bad_pct) ? 2'b11 : 2'($urandom_range(0, 2));
    return w;
  endfunction

  // Driver: full transaction with latency, backpressure and scoreboard checks
  task automatic run_txn(input logic [1:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input int hold, input string name);
    int t;
    int lat;
    logic [W:0] exp;
    logic [W-1:0] held_res;
    logic held_err;
    exp_q.push_back(ref_word(o, av, bv));
    t = 0;
    while (!bus.in_ready && t < 50) begin step(); t++; end
    total++;
    if (!bus.in_ready) begin
      bad++;
      $display("FAIL %s in_ready_wait: got in_ready=%0b want 1", name, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = (hold == 0);
    step();
    // Scramble inputs after accept; they must not matter.
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    total++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s run_flags: got in_ready=%0b busy=%0b want 0 1", name, bus.in_ready, bus.busy);
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    total++;
    if (lat != N) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, N);
    end
    held_res = bus.result;
    held_err = bus.err;
    for (int h = 0; h < hold; h++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== held_res || bus.err !== held_err) begin
        bad++;
        $display("FAIL %s hold_stable: got v=%0b r=%h e=%0b want v=1 r=%h e=%0b",
                 name, bus.out_valid, bus.result, held_err, held_res, held_err);
      end
    end
    exp = exp_q.pop_front();
    total++;
    if (bus.result !== exp[W-1:0] || bus.err !== exp[W]) begin
      bad++;
      $display("FAIL %s result: got r=%h e=%0b want r=%h e=%0b",
               name, bus.result, bus.err, exp[W-1:0], exp[W]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release: got v=%0b in_ready=%0b busy=%0b want 0 1 0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
        bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0b v=%0b r=%h e=%0b busy=%0b want 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.err, bus.busy);
    end
  endtask

  task automatic test_directed();
    run_txn(2'b00, 8'h92, 8'h5A, 0, "min");
    run_txn(2'b01, 8'h92, 8'h5A, 3, "max_backpressure");
    run_txn(2'b10, 8'h06, 8'h96, 0, "any");
    run_txn(2'b11, 8'h92, 8'h5A, 1, "consensus");
    // Spot-check the model itself against hand-derived words.
    total++;
    if (ref_word(2'b00, 8'h92, 8'h5A) !== 9'h052 || ref_word(2'b01, 8'h92, 8'h5A) !== 9'h09A ||
        ref_word(2'b10, 8'h06, 8'h96) !== 9'h046 || ref_word(2'b11, 8'h92, 8'h5A) !== 9'h056 ||
        ref_word(2'b00, 8'h93, 8'h5A) !== 9'h150) begin
      bad++;
      $display("FAIL model_vectors: got %h want 052", ref_word(2'b00, 8'h92, 8'h5A));
    end
  endtask

  task automatic test_illegal();
    run_txn(2'b00, 8'h93, 8'h5A, 0, "illegal_trit");
    run_txn(2'b00, 8'h92, 8'h5A, 0, "clean_after_illegal");
    run_txn(2'b11, 8'h12, 8'hF0, 2, "illegal_b_high");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++)
      run_txn(2'($urandom_range(0, 3)), rand_word(10), rand_word(10),
              $urandom_range(0, 2), "random");
  endtask

  task automatic test_back_to_back();
    logic [W:0] e1;
    logic [W:0] e2;
    logic [W-1:0] a2;
    logic [W-1:0] b2;
    int lat;
    a2 = rand_word(0);
    b2 = rand_word(0);
    e1 = ref_word(2'b01, 8'h26, 8'h18);
    e2 = ref_word(2'b10, a2, b2);
    bus.in_valid = 1'b1;
    bus.op = 2'b01; bus.a = 8'h26; bus.b = 8'h18;
    step();
    // Second request held high with new operands throughout RUN and DONE.
    bus.op = 2'b10; bus.a = a2; bus.b = b2;
    for (int c = 0; c < N; c++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL held_req_flags: got in_ready=%0b busy=%0b want 0 1", bus.in_ready, bus.busy);
      end
      step();
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== e1[W-1:0] || bus.err !== e1[W] || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL held_req_first: got v=%0b r=%h e=%0b rdy=%0b want 1 %h %0b 0",
               bus.out_valid, bus.result, bus.err, bus.in_ready, e1[W-1:0], e1[W]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL held_req_idle: got in_ready=%0b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    total++;
    if (lat != N || bus.result !== e2[W-1:0] || bus.err !== e2[W]) begin
      bad++;
      $display("FAIL held_req_second: got lat=%0d r=%h e=%0b want %0d %h %0b",
               lat, bus.result, bus.err, N, e2[W-1:0], e2[W]);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bus.in_valid = 1'b1;
    bus.op = 2'b01; bus.a = 8'h9A; bus.b = 8'h9A;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_run: got v=%0b r=%h rdy=%0b busy=%0b e=%0b want 0 00 1 0 0",
               bus.out_valid, bus.result, bus.in_ready, bus.busy, bus.err);
    end
    // No stray result should appear after the abort.
    for (int c = 0; c < N + 2; c++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_abort_quiet: got out_valid=%0b want 0", bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    run_txn(2'b10, 8'h2A, 8'h19, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_word_sequencer.md
Name: ternary_word_sequencer

Overview:
- Serial controller that applies one ternary operation (min, max, any, consensus) element-wise across two NTRITS-wide trit words.
- Processes one trit pair per cycle through a single shared ternary operation unit.
- Sits between a host issuing word-level ternary operations and the gate-level ternary datapath, sequencing that datapath and handshaking both ends.

Parameters:
- NTRITS, 8, number of trits per operand/result word (≥2)
- IDXW, $clog2(NTRITS), trit index counter width (derived, not overridden)

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- op  input  2  00 MIN, 01 MAX, 10 ANY, 11 CONSENSUS
- a  input  2*NTRITS  operand A; trit i at bits [2i+1:2i]
- b  input  2*NTRITS  operand B; same packing
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  2*NTRITS  result word; same packing
- err  output  1  illegal trit encoding seen in this transaction
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on rising clk.
- Trit encoding: 00=0, 01=1, 10=2, 11=illegal.
- Operations on a trit pair:
  - MIN = numeric min.
  - MAX = numeric max.
  - ANY: 0,0→0; 0,1→0; 0,2→1; 1,1→1; 1,2→2; 2,2→2; commutative.
  - CONSENSUS: 0,0→0; 2,2→2; all other pairs→1.
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; err=0; busy=0; index=0. Asserting rst_n low mid-RUN or mid-DONE aborts the transaction with no output.
- FSM IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op, a, b; clear result and err; index=0; go RUN.
- RUN:
  - in_ready=0.
  - Each cycle, trit[index] of the latched operands feeds the op unit; the output is written to result[2*index+1:2*index].
  - If either input trit is 11: write 00 and set err (sticky until next accept).
  - index increments. On the edge that writes index NTRITS-1: go DONE, out_valid=1.
- DONE:
  - out_valid=1; result and err held stable.
  - On out_ready: out_valid=0, go IDLE.
  - out_ready ignored in other states.
- Latency: out_valid asserts exactly NTRITS rising edges after the accept edge.
- Throughput: one word per NTRITS+2 cycles minimum (accept edge, NTRITS run edges, release edge). in_ready is low in RUN and DONE; a request held during those states waits.
- Input changes on a/b/op after accept have no effect.
- result and err are meaningful only while out_valid=1.
- Index counter never wraps past NTRITS-1.

Decomposition:
- Shared package ternary_pkg:
  - trit encoding constants T0=2'b00, T1=2'b01, T2=2'b10, TBAD=2'b11
  - op codes OP_MIN, OP_MAX, OP_ANY, OP_CONS
  - FSM state typedef
- Sub-module ternary_op_unit:
  - Combinational; 2-bit a, b, 2-bit op, 2-bit out, bad flag.
  - Instantiates the existing ternary_min, ternary_max, ternary_any and ternary_consensus gate modules and muxes by op.
  - Sequencer holds only FSM, counter and registers.

Test Plan (NTRITS=4):
- MIN: op=00, a=8'h92, b=8'h5A, out_ready=1 → out_valid 4 edges after accept, result=8'h52, err=0.
- MAX: op=01, same operands → result=8'h9A. Hold out_ready=0 for 3 cycles → out_valid and result stable until release.
- ANY: op=10, a=8'h06, b=8'h96 → result=8'h46. CONSENSUS: op=11, a=8'h92, b=8'h5A → result=8'h56.
- Illegal trit: op=00, a=8'h93 (trit0=11), b=8'h5A → result=8'h50, err=1. The next clean transaction returns err=0.
- Handshake/reset:
  - in_valid held high with new operands during RUN → not accepted until IDLE; in_ready=0, busy=1 throughout.
  - rst_n low for one cycle mid-RUN → next cycle IDLE, out_valid=0, result=0, in_ready=1.
